// File: rtl/div_rr_pkg.sv
// div_rr_pkg: shared FSM state type and constants for the round-robin divider scheduler
package div_rr_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
   localparam int MAX_LEN = 64;
   localparam logic [MAX_LEN-1:0] DZ_QUOT = '1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr, wrapping modulo NREQ
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDXW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic            any,
   output logic [IDXW-1:0] idx
);
   logic [IDXW-1:0] j;
   logic hit;
   always_comb begin
      any = |req;
      idx = ptr;
      j = ptr;
      hit = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!hit && req[j]) begin
            idx = j;
            hit = 1'b1;
         end
         j = (j == IDXW'(NREQ - 1)) ? '0 : j + IDXW'(1);
      end
   end
endmodule

// File: rtl/div_rr_sched.sv
// div_rr_sched: round-robin scheduler sharing one external sequential divider among NREQ requesters.
// Define DIV_ZERO_BYPASS_EN to answer B==0 requests locally (Q=all-ones, R=A, RSP_DZ=1) without the divider.
module div_rr_sched
   import div_rr_pkg::*;
#(
   parameter int LEN = 16,
   parameter int NREQ = 4,
   localparam int IDXW = $clog2(NREQ)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NREQ-1:0]     REQ,
   input  logic [NREQ*LEN-1:0] A,
   input  logic [NREQ*LEN-1:0] B,
   output logic [NREQ-1:0]     RSP_VALID,
   output logic [LEN-1:0]      Q,
   output logic [LEN-1:0]      R,
   output logic                RSP_DZ,
   output logic                BUSY,
   output logic [IDXW-1:0]     GNT_IDX,
   output logic                DIV_START,
   output logic [LEN-1:0]      DIV_A,
   output logic [LEN-1:0]      DIV_B,
   input  logic                DIV_DONE,
   input  logic [LEN-1:0]      DIV_Q,
   input  logic [LEN-1:0]      DIV_R
);
   state_t state, state_nx;
   logic any, bypass;
   logic [IDXW-1:0] win, ptr, gnt;
   logic [LEN-1:0] a_arr [NREQ];
   logic [LEN-1:0] b_arr [NREQ];
   logic [LEN-1:0] div_a, div_b, q, r;
   logic [NREQ-1:0] rsp_valid;
   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign a_arr[i] = A[i*LEN +: LEN];
      assign b_arr[i] = B[i*LEN +: LEN];
   end
   rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
      .req(REQ),
      .ptr(ptr),
      .any(any),
      .idx(win)
   );
`ifdef DIV_ZERO_BYPASS_EN
   logic dz;
   assign bypass = b_arr[win] == '0;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         dz <= 1'b0;
      else if (state == IDLE && any && bypass)
         dz <= 1'b1;
      else if (state == WAIT && DIV_DONE)
         dz <= 1'b0;
   end
   assign RSP_DZ = dz;
`else
   assign bypass = 1'b0;
   assign RSP_DZ = 1'b0;
`endif
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = !any ? IDLE : bypass ? RESPOND : ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = DIV_DONE ? RESPOND : WAIT;
         default: state_nx = IDLE;
      endcase
   end
   // RESPOND never arbitrates, giving the grantee one edge to drop REQ before the next pick
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_a <= '0;
         div_b <= '0;
         gnt <= '0;
         ptr <= '0;
         q <= '0;
         r <= '0;
         rsp_valid <= '0;
      end else begin
         rsp_valid <= '0;
         if (state == IDLE && any) begin
            div_a <= a_arr[win];
            div_b <= b_arr[win];
            gnt <= win;
            if (bypass) begin
               q <= DZ_QUOT[LEN-1:0];
               r <= a_arr[win];
               rsp_valid[win] <= 1'b1;
            end
         end
         if (state == WAIT && DIV_DONE) begin
            q <= DIV_Q;
            r <= DIV_R;
            rsp_valid[gnt] <= REQ[gnt];
         end
         if (state == RESPOND)
            ptr <= (gnt == IDXW'(NREQ - 1)) ? '0 : gnt + IDXW'(1);
      end
   end
   assign RSP_VALID = rsp_valid;
   assign Q = q;
   assign R = r;
   assign BUSY = state != IDLE;
   assign GNT_IDX = gnt;
   assign DIV_START = state == ISSUE;
   assign DIV_A = div_a;
   assign DIV_B = div_b;
endmodule

// File: tb/tb_div_rr_sched.sv
// tb_div_rr_sched: scoreboard bench for div_rr_sched with a behavioural LEN-cycle divider
module tb_div_rr_sched;
   localparam int LEN = 16;
   localparam int NREQ = 4;
   localparam int IDXW = 2;
`ifdef DIV_ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   typedef struct {
      int idx;
      logic [LEN-1:0] a, b, q, r;
      logic dz;
      int lat;
      int starts;
   } exp_t;
   logic CLK = 1'b0;
   logic RST;
   logic [NREQ-1:0] REQ;
   logic [NREQ*LEN-1:0] A, B;
   logic [NREQ-1:0] RSP_VALID;
   logic [LEN-1:0] Q, R, DIV_A, DIV_B, DIV_Q, DIV_R;
   logic RSP_DZ, BUSY, DIV_START, DIV_DONE;
   logic [IDXW-1:0] GNT_IDX;
   exp_t exp_q[$];
   exp_t e;
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, grant_cyc = 0, starts = 0, tmo = 0;
   logic busy_q = 1'b0;
   logic fin = 1'b0;
   int dcnt = 0;
   logic [LEN-1:0] da = '0, db = '0;
   int qt[4] = '{0, 3, 6, 10};
   int rt[4] = '{0, 1, 2, 0};

   div_rr_sched #(.LEN(LEN), .NREQ(NREQ)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .A(A), .B(B),
      .RSP_VALID(RSP_VALID), .Q(Q), .R(R), .RSP_DZ(RSP_DZ), .BUSY(BUSY),
      .GNT_IDX(GNT_IDX), .DIV_START(DIV_START), .DIV_A(DIV_A), .DIV_B(DIV_B),
      .DIV_DONE(DIV_DONE), .DIV_Q(DIV_Q), .DIV_R(DIV_R)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // divider without reset: START restarts it, DONE is seen at the LEN+1th edge after START
   always @(posedge CLK) begin
      if (DIV_START) begin
         dcnt <= LEN + 1;
         da <= DIV_A;
         db <= DIV_B;
      end else if (dcnt > 0)
         dcnt <= dcnt - 1;
   end
   assign DIV_DONE = dcnt == 1;
   assign DIV_Q = (db == '0) ? '1 : da / db;
   assign DIV_R = (db == '0) ? da : da % db;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   always @(negedge CLK or posedge RST) begin
      if (RST) begin
         #1;
         busy_q = 1'b0;
         chk("rst_busy", 32'(BUSY), 0);
         chk("rst_valid", 32'(RSP_VALID), 0);
         chk("rst_q", 32'(Q), 0);
         chk("rst_r", 32'(R), 0);
         chk("rst_dz", 32'(RSP_DZ), 0);
         chk("rst_gnt", 32'(GNT_IDX), 0);
         chk("rst_start", 32'(DIV_START), 0);
         chk("rst_div_a", 32'(DIV_A), 0);
         chk("rst_div_b", 32'(DIV_B), 0);
      end else if (fin) begin
         chk("pending", 32'(exp_q.size()), 0);
         chk("timeouts", 32'(tmo), 0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end else begin
         if (BUSY && !busy_q) begin
            grant_cyc = cyc;
            starts = 0;
         end
         busy_q = BUSY;
         if (DIV_START) starts++;
         if (RSP_VALID != '0) begin
            if (exp_q.size() == 0)
               chk("unexpected_rsp", 32'(RSP_VALID), 0);
            else begin
               e = exp_q.pop_front();
               chk("rsp_onehot", 32'(RSP_VALID), 32'(1) << e.idx);
               chk("gnt_idx", 32'(GNT_IDX), 32'(e.idx));
               chk("q", 32'(Q), 32'(e.q));
               chk("r", 32'(R), 32'(e.r));
               chk("dz", 32'(RSP_DZ), 32'(e.dz));
               chk("div_a", 32'(DIV_A), 32'(e.a));
               chk("div_b", 32'(DIV_B), 32'(e.b));
               chk("latency", 32'(cyc - grant_cyc), 32'(e.lat));
               chk("start_pulses", 32'(starts), 32'(e.starts));
            end
         end
      end
   end

   task automatic set_op(input int i, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
      A[i*LEN +: LEN] = a;
      B[i*LEN +: LEN] = b;
   endtask

   task automatic exp_op(input int i, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                         input logic [LEN-1:0] q, input logic [LEN-1:0] r, input logic zero);
      exp_t x;
      logic bp;
      bp = zero & BYPASS;
      x.idx = i;
      x.a = a;
      x.b = b;
      x.q = q;
      x.r = r;
      x.dz = bp;
      x.lat = bp ? 0 : LEN + 2;
      x.starts = bp ? 0 : 1;
      exp_q.push_back(x);
   endtask

   // one cycle of requester behaviour: drop REQ the edge after its RSP_VALID
   task automatic step();
      logic [NREQ-1:0] drop;
      @(negedge CLK);
      drop = RSP_VALID;
      @(posedge CLK);
      #1;
      REQ = REQ & ~drop;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while ((REQ != '0 || BUSY) && k < 200);
      if (REQ != '0 || BUSY) tmo++;
   endtask

   task automatic wait_busy(input logic lvl);
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         if (BUSY === lvl) return;
      end
      tmo++;
   endtask

   task automatic pulse_rst();
      @(posedge CLK);
      #2 RST = 1'b1;
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
   endtask

   initial begin
      REQ = '0;
      A = '0;
      B = '0;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;
      @(posedge CLK);
      #1;
      set_op(0, 16'd100, 16'd7);
      exp_op(0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
      REQ = 4'b0001;
      wait_idle();
      pulse_rst();
      for (int i = 0; i < 4; i++) begin
         set_op(i, 16'(i * 10), 16'd3);
         exp_op(i, 16'(i * 10), 16'd3, 16'(qt[i]), 16'(rt[i]), 1'b0);
      end
      REQ = 4'b1111;
      wait_idle();
      set_op(0, 16'd100, 16'd7);
      set_op(2, 16'd20, 16'd3);
      exp_op(0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
      exp_op(2, 16'd20, 16'd3, 16'd6, 16'd2, 1'b0);
      REQ = 4'b0101;
      wait_idle();
      set_op(0, 16'd50, 16'd5);
      REQ = 4'b0001;
      wait_busy(1'b1);
      repeat (5) @(posedge CLK);
      #1;
      set_op(1, 16'd9, 16'd2);
      exp_op(1, 16'd9, 16'd2, 16'd4, 16'd1, 1'b0);
      REQ = 4'b0010;
      wait_busy(1'b0);
      wait_idle();
      set_op(2, 16'h1234, 16'h0000);
      exp_op(2, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);
      REQ = 4'b0100;
      wait_idle();
      set_op(1, 16'd7, 16'd1);
      REQ = 4'b0010;
      wait_busy(1'b1);
      repeat (6) @(posedge CLK);
      #2 RST = 1'b1;
      REQ = '0;
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
      set_op(3, 16'hFFFF, 16'h0001);
      exp_op(3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
      REQ = 4'b1000;
      wait_idle();
      set_op(2, 16'h8000, 16'hFFFF);
      exp_op(2, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
      REQ = 4'b0100;
      wait_idle();
      fin = 1'b1;
   end
endmodule
